alu_regfile_ctrl: RTL and testbench

Instruction sequencer for the alu_regfile datapath.
- Accepts one instruction at a time over a valid/ready handshake. An instruction is either an ALU op on two registers or a load-immediate.
- Drives the datapath read/write addresses, opcode, carry-in and write port.
- Captures the ALU result and maintains a persistent carry flag, so multi-byte add chains need no testbench intervention.
- Sits between a host or stimulus source and alu_regfile. The datapath's Write_data is fed only by this block.

---
 rtl/alu_regfile_defs.sv | 42 ++++
 rtl/alu_regfile_ctrl.sv | 117 +++++++++++
 tb/tb_alu_regfile_ctrl.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_regfile_defs.sv
// Shared types and widths for the alu_regfile datapath and its sequencer.
// Widths, ALU opcodes, controller state and instruction bundle.
package alu_regfile_defs;

  localparam int REGFILE_ADDR_WIDTH = 4;
  localparam int REGFILE_WIDTH      = 8;
  localparam int ALU_OUTPUT_WIDTH   = 8;

  typedef enum logic [2:0] {
    ADD_OP,
    SUB_OP,
    AND_OP,
    OR_OP,
    EXOR_OP,
    NOT_OP,
    SHL_OP,
    SHR_OP
  } aluop_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WB,
    DONE
  } ctrl_state_t;

  typedef struct packed {
    logic                          load;
    aluop_t                        opcode;
    logic [REGFILE_ADDR_WIDTH-1:0] src_a;
    logic [REGFILE_ADDR_WIDTH-1:0] src_b;
    logic [REGFILE_ADDR_WIDTH-1:0] dest;
    logic [REGFILE_WIDTH-1:0]      imm;
    logic                          use_carry;
  } instr_t;

  // Only the arithmetic ops own the carry flag.
  function automatic logic op_sets_carry(aluop_t op);
    return (op == ADD_OP) || (op == SUB_OP);
  endfunction

endpackage

// File: rtl/alu_regfile_ctrl.sv
// Instruction sequencer for alu_regfile: IDLE -> EXEC -> WB -> DONE.
// Optional ALU_CTRL_ZERO_FLAG_EN adds a Zero_Flag output updated in WB.
module alu_regfile_ctrl
  import alu_regfile_defs::*;
(
  input  logic                          Clock,
  input  logic                          Reset_n,
  input  logic                          Instr_Valid,
  output logic                          Instr_Ready,
  input  logic                          Instr_Load,
  input  aluop_t                        Instr_Opcode,
  input  logic [REGFILE_ADDR_WIDTH-1:0] Instr_Src_A,
  input  logic [REGFILE_ADDR_WIDTH-1:0] Instr_Src_B,
  input  logic [REGFILE_ADDR_WIDTH-1:0] Instr_Dest,
  input  logic [REGFILE_WIDTH-1:0]      Instr_Imm,
  input  logic                          Instr_Use_Carry,
  output logic [REGFILE_ADDR_WIDTH-1:0] Read_Addr_1,
  output logic [REGFILE_ADDR_WIDTH-1:0] Read_Addr_2,
  output logic [REGFILE_ADDR_WIDTH-1:0] Write_Addr,
  output logic                          Write_enable,
  output logic [REGFILE_WIDTH-1:0]      Write_data,
  output logic                          Carry_In,
  output aluop_t                        Opcode,
  input  logic [ALU_OUTPUT_WIDTH-1:0]   ALU_Out,
  input  logic                          Carry_Out,
  output logic                          Done,
  output logic [REGFILE_WIDTH-1:0]      Result,
`ifdef ALU_CTRL_ZERO_FLAG_EN
  output logic                          Zero_Flag,
`endif
  output logic                          Carry_Flag
);

  ctrl_state_t                   state_q;
  aluop_t                        op_q;
  logic [REGFILE_ADDR_WIDTH-1:0] dest_q;
  instr_t                        in_w;

  assign in_w = '{
    load:      Instr_Load,
    opcode:    Instr_Opcode,
    src_a:     Instr_Src_A,
    src_b:     Instr_Src_B,
    dest:      Instr_Dest,
    imm:       Instr_Imm,
    use_carry: Instr_Use_Carry
  };

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      op_q         <= ADD_OP;
      dest_q       <= '0;
      Instr_Ready  <= 1'b1;
      Read_Addr_1  <= '0;
      Read_Addr_2  <= '0;
      Write_Addr   <= '0;
      Write_enable <= 1'b0;
      Write_data   <= '0;
      Carry_In     <= 1'b0;
      Opcode       <= ADD_OP;
      Done         <= 1'b0;
      Result       <= '0;
      Carry_Flag   <= 1'b0;
`ifdef ALU_CTRL_ZERO_FLAG_EN
      Zero_Flag    <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (Instr_Valid) begin
            Instr_Ready <= 1'b0;
            op_q        <= in_w.opcode;
            dest_q      <= in_w.dest;
            if (in_w.load) begin
              // Loads skip EXEC: the write port is set up right away.
              state_q      <= WB;
              Write_enable <= 1'b1;
              Write_Addr   <= in_w.dest;
              Write_data   <= in_w.imm;
            end else begin
              state_q     <= EXEC;
              Read_Addr_1 <= in_w.src_a;
              Read_Addr_2 <= in_w.src_b;
              Opcode      <= in_w.opcode;
              Carry_In    <= in_w.use_carry & Carry_Flag;
            end
          end
        end
        EXEC: begin
          state_q      <= WB;
          Write_enable <= 1'b1;
          Write_Addr   <= dest_q;
          Write_data   <= ALU_Out[REGFILE_WIDTH-1:0];
          if (op_sets_carry(op_q))
            Carry_Flag <= Carry_Out;
        end
        WB: begin
          state_q      <= DONE;
          Write_enable <= 1'b0;
          Done         <= 1'b1;
          Result       <= Write_data;
`ifdef ALU_CTRL_ZERO_FLAG_EN
          Zero_Flag    <= (Write_data == '0);
`endif
        end
        DONE: begin
          state_q     <= IDLE;
          Done        <= 1'b0;
          Instr_Ready <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_regfile_ctrl.sv
// Randomised bench for alu_regfile_ctrl with a behavioural datapath.
// Set ALU_CTRL_ZERO_FLAG_EN to also exercise Zero_Flag.
module tb_alu_regfile_ctrl;
  import alu_regfile_defs::*;

  logic       Clock = 1'b0;
  logic       Reset_n;
  logic       Instr_Valid;
  logic       Instr_Ready;
  logic       Instr_Load;
  aluop_t     Instr_Opcode;
  logic [3:0] Instr_Src_A;
  logic [3:0] Instr_Src_B;
  logic [3:0] Instr_Dest;
  logic [7:0] Instr_Imm;
  logic       Instr_Use_Carry;
  logic [3:0] Read_Addr_1;
  logic [3:0] Read_Addr_2;
  logic [3:0] Write_Addr;
  logic       Write_enable;
  logic [7:0] Write_data;
  logic       Carry_In;
  aluop_t     Opcode;
  logic [7:0] ALU_Out;
  logic       Carry_Out;
  logic       Done;
  logic [7:0] Result;
  logic       Carry_Flag;
`ifdef ALU_CTRL_ZERO_FLAG_EN
  logic       Zero_Flag;
  logic       exp_z;
`endif

  int n_chk = 0;
  int n_bad = 0;

  logic [7:0] rf [16] = '{default: 8'h00};
  logic [7:0] exp_rf [16];
  logic       exp_c;
  logic [7:0] exp_res;

  always #5 Clock = ~Clock;

  alu_regfile_ctrl dut (
    .Clock(Clock),
    .Reset_n(Reset_n),
    .Instr_Valid(Instr_Valid),
    .Instr_Ready(Instr_Ready),
    .Instr_Load(Instr_Load),
    .Instr_Opcode(Instr_Opcode),
    .Instr_Src_A(Instr_Src_A),
    .Instr_Src_B(Instr_Src_B),
    .Instr_Dest(Instr_Dest),
    .Instr_Imm(Instr_Imm),
    .Instr_Use_Carry(Instr_Use_Carry),
    .Read_Addr_1(Read_Addr_1),
    .Read_Addr_2(Read_Addr_2),
    .Write_Addr(Write_Addr),
    .Write_enable(Write_enable),
    .Write_data(Write_data),
    .Carry_In(Carry_In),
    .Opcode(Opcode),
    .ALU_Out(ALU_Out),
    .Carry_Out(Carry_Out),
    .Done(Done),
    .Result(Result),
`ifdef ALU_CTRL_ZERO_FLAG_EN
    .Zero_Flag(Zero_Flag),
`endif
    .Carry_Flag(Carry_Flag)
  );

  // ALU semantics; carry is the 9th bit of add, borrow of subtract.
  function automatic logic [8:0] alu_f(aluop_t op, logic [7:0] a,
                                       logic [7:0] b, logic c);
    case (op)
      ADD_OP:  return {1'b0, a} + {1'b0, b} + {8'd0, c};
      SUB_OP:  return {1'b0, a} - {1'b0, b} - {8'd0, c};
      AND_OP:  return {1'b1, a & b};
      OR_OP:   return {1'b1, a | b};
      EXOR_OP: return {1'b1, a ^ b};
      NOT_OP:  return {1'b0, ~a};
      SHL_OP:  return {a, 1'b0};
      default: return {a[0], 1'b0, a[7:1]};
    endcase
  endfunction

  always @(posedge Clock)
    if (Write_enable) rf[Write_Addr] <= Write_data;

  always_comb
    {Carry_Out, ALU_Out} = alu_f(Opcode, rf[Read_Addr_1],
                                 rf[Read_Addr_2], Carry_In);

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rdy"}, 32'(Instr_Ready), 1);
    chk({tag, "_we"}, 32'(Write_enable), 0);
    chk({tag, "_done"}, 32'(Done), 0);
    chk({tag, "_addr"}, {Read_Addr_1, Read_Addr_2, Write_Addr}, 0);
    chk({tag, "_wd"}, 32'(Write_data), 0);
    chk({tag, "_res"}, 32'(Result), 0);
    chk({tag, "_cf"}, 32'(Carry_Flag), 0);
    chk({tag, "_cin"}, 32'(Carry_In), 0);
    chk({tag, "_op"}, 32'(Opcode), 32'(ADD_OP));
`ifdef ALU_CTRL_ZERO_FLAG_EN
    chk({tag, "_zf"}, 32'(Zero_Flag), 0);
`endif
  endtask

  // Issue one instruction from a negedge and follow it to retirement.
  task automatic run(input bit ld, input aluop_t op, input logic [3:0] a,
                     input logic [3:0] b, input logic [3:0] d,
                     input logic [7:0] imm, input bit uc);
    logic [8:0] r;
    logic       cin;
    logic [7:0] val;
    int         lat;
    int         w;
    w = 0;
    while (!Instr_Ready && w < 10) begin
      @(negedge Clock);
      w++;
    end
    if (!Instr_Ready) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    cin = uc ? exp_c : 1'b0;
    if (ld) begin
      val = imm;
    end else begin
      r = alu_f(op, exp_rf[a], exp_rf[b], cin);
      val = r[7:0];
      if (op == ADD_OP || op == SUB_OP) exp_c = r[8];
    end
    Instr_Valid = 1'b1;
    Instr_Load = ld;
    Instr_Opcode = op;
    Instr_Src_A = a;
    Instr_Src_B = b;
    Instr_Dest = d;
    Instr_Imm = imm;
    Instr_Use_Carry = uc;
    @(posedge Clock);
    #1 Instr_Valid = 1'b0;
    lat = ld ? 2 : 3;
    for (int cyc = 1; cyc <= lat + 1; cyc++) begin
      @(negedge Clock);
      chk("ready", 32'(Instr_Ready), 32'(cyc == lat + 1));
      chk("we", 32'(Write_enable), 32'(cyc == lat - 1));
      chk("done", 32'(Done), 32'(cyc == lat));
      if (!ld && cyc == 1) begin
        chk("ra1", 32'(Read_Addr_1), 32'(a));
        chk("ra2", 32'(Read_Addr_2), 32'(b));
        chk("opc", 32'(Opcode), 32'(op));
        chk("cin", 32'(Carry_In), 32'(cin));
      end
      if (cyc == lat - 1) begin
        chk("waddr", 32'(Write_Addr), 32'(d));
        chk("wdata", 32'(Write_data), 32'(val));
      end
    end
    exp_rf[d] = val;
    exp_res = val;
    chk("result", 32'(Result), 32'(exp_res));
    chk("carry", 32'(Carry_Flag), 32'(exp_c));
    chk("rf", 32'(rf[d]), 32'(val));
`ifdef ALU_CTRL_ZERO_FLAG_EN
    exp_z = (val == 8'h00);
    chk("zero", 32'(Zero_Flag), 32'(exp_z));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int acc;
    int dn;
    for (int i = 0; i < 16; i++) exp_rf[i] = 8'h00;
    exp_c = 1'b0;
    exp_res = 8'h00;
    Reset_n = 1'b0;
    Instr_Valid = 1'b0;
    Instr_Load = 1'b0;
    Instr_Opcode = ADD_OP;
    Instr_Src_A = '0;
    Instr_Src_B = '0;
    Instr_Dest = '0;
    Instr_Imm = '0;
    Instr_Use_Carry = 1'b0;
    repeat (3) @(negedge Clock);
    chk_reset("rst");
    Reset_n = 1'b1;
    @(negedge Clock);

    run(1, ADD_OP, 0, 0, 0, 8'h55, 0);
    run(1, ADD_OP, 0, 0, 1, 8'hAA, 0);
    run(0, ADD_OP, 0, 1, 4, 8'h00, 0);
    chk("t1_r4", 32'(rf[4]), 32'hFF);

    run(1, ADD_OP, 0, 0, 12, 8'hF0, 0);
    run(1, ADD_OP, 0, 0, 13, 8'h12, 0);
    run(0, ADD_OP, 12, 13, 14, 8'h00, 0);
    chk("t2_r14", 32'(rf[14]), 32'h02);
    chk("t2_cf", 32'(Carry_Flag), 1);
    run(0, EXOR_OP, 12, 13, 11, 8'h00, 0);
    chk("t3_xor", 32'(rf[11]), 32'hE2);
    chk("t3_cf", 32'(Carry_Flag), 1);
    run(1, ADD_OP, 0, 0, 12, 8'h80, 0);
    run(0, ADD_OP, 12, 13, 15, 8'h00, 1);
    chk("t2_r15", 32'(rf[15]), 32'h93);
    chk("t2_cf0", 32'(Carry_Flag), 0);

    // Valid held high across three loads.
    acc = 0;
    dn = 0;
    Instr_Load = 1'b1;
    Instr_Valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge Clock);
      chk("hold_rdy", 32'(Instr_Ready), 32'(i % 3 == 0));
      if (Done) dn++;
      if (Instr_Ready) begin
        Instr_Dest = 4'(5 + acc);
        Instr_Imm = 8'(8'h11 * (acc + 1));
        exp_rf[5 + acc] = Instr_Imm;
        exp_res = Instr_Imm;
        acc++;
      end
    end
    Instr_Valid = 1'b0;
    @(negedge Clock);
    chk("hold_acc", 32'(acc), 3);
    chk("hold_done", 32'(dn), 3);
    chk("hold_r7", 32'(rf[7]), 32'h33);
    chk("hold_res", 32'(Result), 32'(exp_res));
`ifdef ALU_CTRL_ZERO_FLAG_EN
    exp_z = 1'b0;
`endif

    // Reset during EXEC discards the instruction.
    run(1, ADD_OP, 0, 0, 3, 8'h3C, 0);
    Instr_Load = 1'b0;
    Instr_Opcode = ADD_OP;
    Instr_Src_A = 4'd3;
    Instr_Src_B = 4'd3;
    Instr_Dest = 4'd3;
    Instr_Valid = 1'b1;
    @(posedge Clock);
    #1 Instr_Valid = 1'b0;
    @(negedge Clock);
    chk("exec_we", 32'(Write_enable), 0);
    Reset_n = 1'b0;
    #1 chk_reset("async");
    @(negedge Clock);
    chk_reset("mid");
    Reset_n = 1'b1;
    @(negedge Clock);
    @(negedge Clock);
    chk("rst_r3", 32'(rf[3]), 32'h3C);
    chk("rst_we", 32'(Write_enable), 0);
    exp_c = 1'b0;
    exp_res = 8'h00;

`ifdef ALU_CTRL_ZERO_FLAG_EN
    run(0, EXOR_OP, 0, 0, 9, 8'h00, 0);
    chk("zf_set", 32'(Zero_Flag), 1);
    run(1, ADD_OP, 0, 0, 9, 8'h01, 0);
    chk("zf_clr", 32'(Zero_Flag), 0);
`endif

    for (int k = 0; k < 60; k++) begin
      run(1'($urandom_range(0, 3) == 0),
          aluop_t'($urandom_range(0, 7)),
          4'($urandom), 4'($urandom), 4'($urandom),
          8'($urandom), 1'($urandom));
    end
    for (int i = 0; i < 16; i++) chk("final_rf", 32'(rf[i]), 32'(exp_rf[i]));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
